// File: rtl/fifo_512_8.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_512_8
//  Purpose  : Two-entry 512-bit word buffer unpacked to a FWFT byte stream.
//             Optional per-word byte length under macro FIFO_512_8_LEN_EN.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_512_8 (
    input  logic         rst,
    input  logic         wr_clk,
    input  logic [511:0] din,
`ifdef FIFO_512_8_LEN_EN
    input  logic [6:0]   din_len,
`endif
    input  logic         wr_en,
    input  logic         rd_en,
    output logic         full,
    output logic         empty,
    output logic [7:0]   dout
);

    logic [511:0] mem_q [2];
    logic         head_q, head_d;
    logic         tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic [5:0]   idx_q, idx_d;

    logic         w_wr;
    logic         w_rd;
    logic         w_last;
    logic         w_pop;
    logic [511:0] w_head_word;
    logic [8:0]   w_bit_ofs;

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

    assign w_wr = wr_en & ~full;
    assign w_rd = rd_en & ~empty;

`ifdef FIFO_512_8_LEN_EN
    logic [6:0] len_q [2];
    logic [6:0] w_len_norm;

    assign w_len_norm = ((din_len == 7'd0) || (din_len > 7'd64)) ? 7'd64 : din_len;
    assign w_last     = ({1'b0, idx_q} == (len_q[head_q] - 7'd1));

    always_ff @(posedge wr_clk) begin
        if (w_wr) begin
            len_q[tail_q] <= w_len_norm;
        end
    end
`else
    assign w_last = (idx_q == 6'd63);
`endif

    assign w_pop = w_rd & w_last;

    // Payload needs no reset: it is only observed while count is non-zero.
    always_ff @(posedge wr_clk) begin
        if (w_wr) begin
            mem_q[tail_q] <= din;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        idx_d   = idx_q;
        count_d = count_q + {1'b0, w_wr} - {1'b0, w_pop};
        if (w_wr) begin
            tail_d = ~tail_q;
        end
        if (w_pop) begin
            head_d = ~head_q;
            idx_d  = 6'd0;
        end else if (w_rd) begin
            idx_d  = idx_q + 6'd1;
        end
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            idx_q   <= 6'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

    // Lane index counts down from the MSB (64*(7-lane) == 64*~lane); byte within lane counts up.
    assign w_head_word = mem_q[head_q];
    assign w_bit_ofs   = {~idx_q[5:3], idx_q[2:0], 3'b000};
    assign dout        = empty ? 8'd0 : w_head_word[w_bit_ofs +: 8];

endmodule
`default_nettype wire
